intc_ack_ctrl: RTL
==================

INTC_ACK_CTRL -- requirements
Module: intc_ack_ctrl

Interface
REQ-001 Parameter INT_NUM, default 64: number of normal interrupt request lines.
REQ-002 Parameter VEC_BASE, default 64: vector of normal interrupt 0; interrupt i uses vector VEC_BASE+i, truncated to 8 bits.
REQ-003 Parameter VEC_NMI, default 11: NMI vector.
REQ-004 Parameter VEC_ERR, default 9: error interrupt vector.
REQ-005 Parameter TMO_CYC, default 255: request timeout, in cycles; used only when the timeout feature is compiled in.
REQ-006 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port in_intreq_nmi_i, input, 1: pending NMI from capture logic.
REQ-009 Port in_intreq_err_i, input, 1: pending error interrupt from capture logic.
REQ-010 Port in_intreq_i, input, INT_NUM: pending normal interrupts from capture logic.
REQ-011 Port rg_ilvl_i, input, INT_NUM x 4: per-interrupt priority level; 0 disables that interrupt.
REQ-012 Port cpu_imask_i, input, 4: CPU interrupt mask level.
REQ-013 Port cpu_ack_i, input, 1: CPU accepts the presented request.
REQ-014 Port int_req_o, output, 1: interrupt request to the CPU.
REQ-015 Port int_lvl_o, output, 4: level of the presented request.
REQ-016 Port int_vec_o, output, 8: vector of the presented request.
REQ-017 Port cp_intack_nmi_o, output, 1: NMI acknowledge pulse back to capture logic.
REQ-018 Port cp_intack_err_o, output, 1: error acknowledge pulse back to capture logic.
REQ-019 Port cp_intack_o, output, INT_NUM: one-hot normal acknowledge pulse back to capture logic.
REQ-020 Port tmo_o, output, 1: one-cycle pulse when a request is withdrawn on timeout.

Function
REQ-021 Eligibility: NMI is always eligible; ERR has fixed level 15 and is eligible when 15 > cpu_imask_i; normal i is eligible when in_intreq_i[i]=1 and rg_ilvl_i[i] > cpu_imask_i.
REQ-022 Priority order: NMI, then ERR, then normal interrupts by highest level; level ties go to the lowest index.
REQ-023 The FSM SHALL have four states: IDLE, REQ, ACK, HOLD.
REQ-024 IDLE: when any source is eligible, latch winner identity, level (NMI reports 15) and vector; go to REQ; int_req_o rises on the next edge (1-cycle latency from the eligible sample).
REQ-025 REQ: int_req_o=1; int_lvl_o and int_vec_o stay stable; a newly eligible higher-priority source does not preempt.
REQ-026 REQ with cpu_ack_i=1: go to ACK.
REQ-027 REQ with the winner's pending bit deasserted and cpu_ack_i=0: drop int_req_o and go to IDLE with no acknowledge.
REQ-028 REQ with the pending bit deasserted and cpu_ack_i=1 in the same cycle: the acknowledge takes precedence.
REQ-029 ACK: int_req_o=0; assert exactly one acknowledge output (cp_intack_nmi_o, cp_intack_err_o or cp_intack_o[winner]) for exactly one cycle; go to HOLD.
REQ-030 HOLD: one idle cycle so capture logic can clear pending; then IDLE. The minimum request-to-request spacing is therefore 3 cycles.
REQ-031 cpu_ack_i is ignored outside REQ.

Reset
REQ-032 While rst=1, regardless of clk: state=IDLE; int_req_o=0, int_lvl_o=0, int_vec_o=0; all acknowledge outputs=0; tmo_o=0; timeout counter=0.
REQ-033 Reset asserted mid-handshake (REQ or ACK) SHALL abort the handshake with no acknowledge pulse issued.

Configuration
REQ-034 Macro INTC_ACK_TIMEOUT_EN defined: an 8-bit counter clears on entry to REQ and increments each REQ cycle without cpu_ack_i.
REQ-035 With INTC_ACK_TIMEOUT_EN defined: when the counter reaches TMO_CYC, drop int_req_o, pulse tmo_o, issue no acknowledge, and go to HOLD.
REQ-036 Without INTC_ACK_TIMEOUT_EN: REQ waits indefinitely, tmo_o is tied to 0, and no counter exists.

Verification
REQ-037 Test 1: in_intreq_i[5]=1, rg_ilvl_i[5]=7, cpu_imask_i=3 -> int_req_o=1 one cycle later, int_lvl_o=7, int_vec_o=69; cpu_ack_i=1 -> cp_intack_o=1<<5 for one cycle.
REQ-038 Test 2: NMI, ERR and normal 2 (level 14) all pending -> NMI served first (vector 11), then ERR (vector 9), then normal 2 (vector 66), each separated by at least 3 cycles.
REQ-039 Test 3: normals 3 and 9, both at level 6 -> 3 served first; level 0 on 9, or cpu_imask_i=6 -> 9 never requested.
REQ-040 Test 4: in REQ for normal 4, in_intreq_i[4] falls with cpu_ack_i=0 -> int_req_o drops, no cp_intack_o; repeat with cpu_ack_i=1 in the same cycle -> acknowledge issued.
REQ-041 Test 5: rst pulsed asynchronously while in REQ -> all outputs 0 immediately, and no acknowledge after release.
REQ-042 Test 6: INTC_ACK_TIMEOUT_EN defined, TMO_CYC=4, no cpu_ack_i -> int_req_o high for 4 cycles, then tmo_o pulse, request re-presented after HOLD.

Source files
------------

// File: rtl/intc_ack_ctrl.sv
// Interrupt arbiter and CPU request/acknowledge handshake.
// Optional request timeout: define INTC_ACK_TIMEOUT_EN.
module intc_ack_ctrl #(
  parameter int INT_NUM  = 64,
  parameter int VEC_BASE = 64,
  parameter int VEC_NMI  = 11,
  parameter int VEC_ERR  = 9,
  parameter int TMO_CYC  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_intreq_nmi_i,
  input  logic                  in_intreq_err_i,
  input  logic [INT_NUM-1:0]    in_intreq_i,
  input  logic [INT_NUM-1:0][3:0] rg_ilvl_i,
  input  logic [3:0]            cpu_imask_i,
  input  logic                  cpu_ack_i,
  output logic                  int_req_o,
  output logic [3:0]            int_lvl_o,
  output logic [7:0]            int_vec_o,
  output logic                  cp_intack_nmi_o,
  output logic                  cp_intack_err_o,
  output logic [INT_NUM-1:0]    cp_intack_o,
  output logic                  tmo_o
);

  localparam int IW = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;
  typedef enum logic [1:0] {SRC_NMI, SRC_ERR, SRC_NRM} src_t;

  state_t        state;
  src_t          src, win_src;
  logic [IW-1:0] idx, best_idx;
  logic [3:0]    best_lvl, win_lvl;
  logic [7:0]    win_vec;
  logic          best_hit, err_ok, any, pend;

  // Lowest index wins ties because only a strictly higher level replaces it.
  always_comb begin
    best_hit = 1'b0;
    best_lvl = 4'd0;
    best_idx = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (in_intreq_i[i] && (rg_ilvl_i[i] > cpu_imask_i) &&
          (!best_hit || (rg_ilvl_i[i] > best_lvl))) begin
        best_hit = 1'b1;
        best_lvl = rg_ilvl_i[i];
        best_idx = IW'(i);
      end
    end
  end

  assign err_ok = in_intreq_err_i && (cpu_imask_i != 4'hf);
  assign any    = in_intreq_nmi_i || err_ok || best_hit;

  always_comb begin
    win_src = SRC_NRM;
    win_lvl = best_lvl;
    win_vec = 8'(VEC_BASE + int'(best_idx));
    if (in_intreq_nmi_i) begin
      win_src = SRC_NMI;
      win_lvl = 4'hf;
      win_vec = 8'(VEC_NMI);
    end else if (err_ok) begin
      win_src = SRC_ERR;
      win_lvl = 4'hf;
      win_vec = 8'(VEC_ERR);
    end
  end

  always_comb begin
    pend = 1'b0;
    unique case (src)
      SRC_NMI: pend = in_intreq_nmi_i;
      SRC_ERR: pend = in_intreq_err_i;
      default: pend = in_intreq_i[idx];
    endcase
  end

`ifdef INTC_ACK_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
  logic [7:0] cnt;
`else
  assign tmo_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      src             <= SRC_NMI;
      idx             <= '0;
      int_req_o       <= 1'b0;
      int_lvl_o       <= 4'd0;
      int_vec_o       <= 8'd0;
      cp_intack_nmi_o <= 1'b0;
      cp_intack_err_o <= 1'b0;
      cp_intack_o     <= '0;
`ifdef INTC_ACK_TIMEOUT_EN
      tmo_o           <= 1'b0;
      cnt             <= 8'd0;
`endif
    end else begin
      cp_intack_nmi_o <= 1'b0;
      cp_intack_err_o <= 1'b0;
      cp_intack_o     <= '0;
`ifdef INTC_ACK_TIMEOUT_EN
      tmo_o           <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any) begin
            src       <= win_src;
            idx       <= best_idx;
            int_lvl_o <= win_lvl;
            int_vec_o <= win_vec;
            int_req_o <= 1'b1;
            state     <= REQ;
`ifdef INTC_ACK_TIMEOUT_EN
            cnt       <= 8'd0;
`endif
          end
        end
        REQ: begin
          if (cpu_ack_i) begin
            int_req_o        <= 1'b0;
            state            <= ACK;
            cp_intack_nmi_o  <= (src == SRC_NMI);
            cp_intack_err_o  <= (src == SRC_ERR);
            cp_intack_o[idx] <= (src == SRC_NRM);
          end else if (!pend) begin
            int_req_o <= 1'b0;
            state     <= IDLE;
`ifdef INTC_ACK_TIMEOUT_EN
          end else if (cnt + 8'd1 == TMO_LIM) begin
            int_req_o <= 1'b0;
            tmo_o     <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
`endif
          end
        end
        ACK:     state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
